max7219_display_sequencer: RTL and testbench
============================================

Name: max7219_display_sequencer

Overview:
- Controller sitting between the clock core (BCD time digits) and the serial shift unit that drives the MAX7219 display over CS/MOSI/SCK.
- After reset it issues the MAX7219 initialisation sequence.
- It then schedules one digit-register refresh per time update and an intensity rewrite whenever the brightness setting changes.
- Each register write is handed to the serializer as a 16-bit word over a valid/ready handshake.

Parameters:
- NUM_DIGITS, 6, digits driven (1..8); sets scan-limit value and refresh length.
- DECODE_MASK, 8'hFF, value written to decode-mode register (Code-B per digit).
- INIT_INTENSITY, 4'h8, intensity used until the first i_intensity sample differs.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_en  in  1  design enable; low pauses issue of new words.
- i_update  in  1  one-cycle pulse: i_digits holds a new time value.
- i_digits  in  32  8 BCD nibbles; nibble k (bits 4k+3:4k) goes to digit register k+1.
- i_intensity  in  4  requested brightness.
- o_word  out  16  {4'h0, addr[3:0], data[7:0]} to the serializer.
- o_word_valid  out  1  o_word is valid.
- i_word_ready  in  1  serializer accepts o_word this cycle.
- o_init_done  out  1  initialisation sequence complete.
- o_busy  out  1  state is not S_IDLE.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous, active-low, and named i_reset_n.
  - Clock port is i_clk.
- Reset values:
  - o_word = 0, o_word_valid = 0, o_init_done = 0, o_busy = 1.
  - State = S_INIT, word index = 0, pending = 0, digit snapshot = 0, last_intensity = INIT_INTENSITY.
- Handshake:
  - A transfer occurs in any cycle where o_word_valid && i_word_ready.
  - While valid && !ready, o_word is held stable and valid stays high. A word is never withdrawn, even if i_en drops.
  - The next word may be presented the cycle after a transfer, so back-to-back transfers are allowed.
  - All outputs are registered.
- i_en:
  - While i_en = 0, no new word is raised. A word already valid completes normally.
  - The sequence resumes at the same index when i_en returns high.
- S_INIT: issues five words in this order:
  - 0x0F00 (display test off)
  - 0x09 | DECODE_MASK
  - 0x0A | INIT_INTENSITY
  - 0x0B | (NUM_DIGITS-1)
  - 0x0C01 (normal operation)
  - After the 5th transfer: o_init_done = 1 (sticky until reset), then go to S_IDLE.
- i_update capture:
  - Every i_update pulse, in any state, latches i_digits into latest_digits and sets pending.
- S_IDLE priority, evaluated only when i_en = 1:
  1. If i_intensity != last_intensity, go to S_INTENS.
  2. Else if pending, go to S_DIGITS.
  3. Else stay.
- S_DIGITS:
  - On entry: copy latest_digits into snapshot, clear pending, index = 1.
  - Issue words {addr=index, data={4'h0, snapshot nibble index-1}} for index 1..NUM_DIGITS, then return to S_IDLE.
  - An i_update arriving mid-refresh does not alter the words in flight. It sets pending, so exactly one further refresh follows with the newest value.
  - An i_update in the same cycle as entry to S_DIGITS is captured by that refresh, and pending ends at 0.
- S_INTENS:
  - Issues one word 0x0A00 | i_intensity, sampled on entry.
  - last_intensity is updated to that sampled value on transfer.
  - Returns to S_IDLE.
- No state is left except by transfer completion or reset.
- Reset mid-operation:
  - o_word_valid drops on the resetting edge.
  - The FSM restarts S_INIT. The serializer is reset in the same domain.
- Address/width: the digit address is 4 bits. The NUM_DIGITS ≤ 8 constraint is checked by an elaboration-time assertion.

Decomposition:
- Package max7219_pkg contains:
  - Register address constants: REG_NOOP = 0x0, REG_DIGIT0 = 0x1, REG_DECODE = 0x9, REG_INTENSITY = 0xA, REG_SCANLIMIT = 0xB, REG_SHUTDOWN = 0xC, REG_DISPTEST = 0xF.
  - A state enum with values S_INIT, S_IDLE, S_DIGITS, S_INTENS.
  - Function make_word(addr, data).
- Sub-module max7219_init_rom: a combinational index→word table for the 5-word init sequence.

Test Plan:
- Release reset, i_en = 1, i_word_ready = 1 → exactly 0x0F00, 0x09FF, 0x0A08, 0x0B05, 0x0C01 on consecutive cycles, then o_init_done = 1 and o_busy = 0.
- After init, i_update with i_digits = 0x00123456 → six words 0x0106, 0x0205, 0x0304, 0x0403, 0x0502, 0x0601, then idle.
- i_word_ready held low for 10 cycles mid-refresh → o_word stable, valid high throughout, no word skipped or duplicated.
- Two i_update pulses (0x00000001, then 0x00000002) during one refresh → current refresh completes with its original data, then exactly one extra refresh ending 0x0600 with digit1 word 0x0102.
- Set i_intensity = 4'hC while pending is also set → 0x0A0C is issued before the digit words. With i_intensity unchanged, no further intensity writes occur.
- Assert i_reset_n = 0 for one cycle mid-refresh → next cycle o_word_valid = 0, then the init sequence restarts from 0x0F00. Drop i_en mid-sequence → no new valid until i_en returns.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, sequencer state encoding and word packing.
package max7219_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;

  localparam logic [3:0] INIT_LEN = 4'd5;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_DIGITS = 2'd2,
    S_INTENS = 2'd3
  } state_t;

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_init_rom.sv
// Power-up register sequence for the MAX7219, indexed 0..4; out-of-range reads give a no-op word.
module max7219_init_rom
  import max7219_pkg::*;
#(
  parameter int          NUM_DIGITS     = 6,
  parameter logic [7:0]  DECODE_MASK    = 8'hFF,
  parameter logic [3:0]  INIT_INTENSITY = 4'h8
) (
  input  logic [2:0]  idx_i,
  output logic [15:0] word_o
);

  localparam logic [7:0] SCAN_LIMIT = 8'(NUM_DIGITS - 1);

  always_comb begin
    word_o = make_word(REG_NOOP, 8'h00);
    case (idx_i)
      3'd0:    word_o = make_word(REG_DISPTEST, 8'h00);
      3'd1:    word_o = make_word(REG_DECODE, DECODE_MASK);
      3'd2:    word_o = make_word(REG_INTENSITY, {4'h0, INIT_INTENSITY});
      3'd3:    word_o = make_word(REG_SCANLIMIT, SCAN_LIMIT);
      3'd4:    word_o = make_word(REG_SHUTDOWN, 8'h01);
      default: ;
    endcase
  end

endmodule

// File: rtl/max7219_display_sequencer.sv
// Schedules MAX7219 register writes (init, digit refresh, intensity) and hands
// them one 16-bit word at a time to the serializer over valid/ready.
module max7219_display_sequencer
  import max7219_pkg::*;
#(
  parameter int          NUM_DIGITS     = 6,
  parameter logic [7:0]  DECODE_MASK    = 8'hFF,
  parameter logic [3:0]  INIT_INTENSITY = 4'h8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_update,
  input  logic [31:0] i_digits,
  input  logic [3:0]  i_intensity,
  output logic [15:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_init_done,
  output logic        o_busy
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("max7219_display_sequencer: NUM_DIGITS must be within 1..8");
  end

  localparam logic [3:0] DIG_END = 4'(NUM_DIGITS + 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        pending_q, pending_d;
  logic [31:0] latest_q, latest_d;
  logic [31:0] snap_q, snap_d;
  logic [3:0]  last_int_q, last_int_d;
  logic [3:0]  samp_q, samp_d;

  logic        fire;
  logic [3:0]  last_idx;
  logic [15:0] cur_word;
  logic [15:0] rom_word;
  logic [2:0]  nib_sel;
  logic [3:0]  nib;

  max7219_init_rom #(
    .NUM_DIGITS    (NUM_DIGITS),
    .DECODE_MASK   (DECODE_MASK),
    .INIT_INTENSITY(INIT_INTENSITY)
  ) u_init_rom (
    .idx_i (idx_q[2:0]),
    .word_o(rom_word)
  );

  // Digit register k+1 carries BCD nibble k of the snapshot.
  assign nib_sel = 3'(idx_q - 4'd1);
  assign nib     = 4'(snap_q >> {nib_sel, 2'b00});

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    valid_d     = valid_q;
    init_done_d = init_done_q;
    pending_d   = pending_q;
    latest_d    = latest_q;
    snap_d      = snap_q;
    last_int_d  = last_int_q;
    samp_d      = samp_q;
    last_idx    = 4'd0;
    cur_word    = 16'h0000;
    fire        = valid_q && i_word_ready;

    if (i_update) begin
      pending_d = 1'b1;
      latest_d  = i_digits;
    end

    case (state_q)
      S_INIT:   begin last_idx = INIT_LEN; cur_word = rom_word; end
      S_DIGITS: begin last_idx = DIG_END;  cur_word = make_word(idx_q, {4'h0, nib}); end
      S_INTENS: begin last_idx = 4'd1;     cur_word = make_word(REG_INTENSITY, {4'h0, samp_q}); end
      default:  ;
    endcase

    if (state_q == S_IDLE) begin
      if (i_en) begin
        if (i_intensity != last_int_q) begin
          state_d = S_INTENS;
          idx_d   = 4'd0;
          samp_d  = i_intensity;
        end else if (pending_q) begin
          // A same-cycle update is folded into this refresh, so nothing stays pending.
          state_d   = S_DIGITS;
          idx_d     = 4'd1;
          snap_d    = i_update ? i_digits : latest_q;
          pending_d = 1'b0;
        end
      end
    end else if (!valid_q || fire) begin
      // idx counts words already presented; reaching last_idx means the final word is out.
      if (idx_q != last_idx) begin
        valid_d = i_en;
        if (i_en) begin
          word_d = cur_word;
          idx_d  = idx_q + 4'd1;
        end
      end else if (fire) begin
        valid_d = 1'b0;
        state_d = S_IDLE;
        if (state_q == S_INIT)   init_done_d = 1'b1;
        if (state_q == S_INTENS) last_int_d  = samp_q;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_INIT;
      idx_q       <= 4'd0;
      word_q      <= 16'h0000;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      pending_q   <= 1'b0;
      latest_q    <= 32'h0;
      snap_q      <= 32'h0;
      last_int_q  <= INIT_INTENSITY;
      samp_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      latest_q    <= latest_d;
      snap_q      <= snap_d;
      last_int_q  <= last_int_d;
      samp_q      <= samp_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_init_done  = init_done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_max7219_display_sequencer.sv
// Directed bench for max7219_display_sequencer: init sequence, refresh vectors, stalls, reset and enable.
module tb_max7219_display_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        update;
  logic [31:0] digits;
  logic [3:0]  intensity;
  logic [15:0] word;
  logic        valid;
  logic        ready;
  logic        init_done;
  logic        busy;

  max7219_display_sequencer #(
    .NUM_DIGITS    (6),
    .DECODE_MASK   (8'hFF),
    .INIT_INTENSITY(4'h8)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_en        (en),
    .i_update    (update),
    .i_digits    (digits),
    .i_intensity (intensity),
    .o_word      (word),
    .o_word_valid(valid),
    .i_word_ready(ready),
    .o_init_done (init_done),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] got_q[$];
  int          got_cyc[$];

  // Inputs only change just after a rising edge, so the falling edge sees what the next edge will see.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      got_q.push_back(word);
      got_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]      digits;
    logic [5:0][15:0] exp;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] init_exp[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (got_q.size() < n) check("timeout_words", got_q.size(), n);
  endtask

  task automatic pulse(input logic [31:0] d);
    digits = d;
    update = 1'b1;
    tick(1);
    update = 1'b0;
  endtask

  task automatic check_init_words(input string tag);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check({tag, "_word"}, got_q[i], init_exp[i]);
      else                  check({tag, "_missing"}, i, 5);
    end
  endtask

  logic [15:0] held;

  initial begin
    vecs[0].digits = 32'h00123456;
    vecs[0].exp    = {16'h0601, 16'h0502, 16'h0403, 16'h0304, 16'h0205, 16'h0106};
    vecs[1].digits = 32'h00987654;
    vecs[1].exp    = {16'h0609, 16'h0508, 16'h0407, 16'h0306, 16'h0205, 16'h0104};
    vecs[2].digits = 32'h00000000;
    vecs[2].exp    = {16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100};
    vecs[3].digits = 32'hFF90A1B2;
    vecs[3].exp    = {16'h0609, 16'h0500, 16'h040A, 16'h0301, 16'h020B, 16'h0102};
    init_exp[0] = 16'h0F00;
    init_exp[1] = 16'h09FF;
    init_exp[2] = 16'h0A08;
    init_exp[3] = 16'h0B05;
    init_exp[4] = 16'h0C01;

    rst_n = 1'b0; en = 1'b1; update = 1'b0; digits = 32'h0;
    intensity = 4'h8; ready = 1'b1;
    tick(3);
    check("rst_word", word, 16'h0000);
    check("rst_valid", valid, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b1);

    // Init sequence back to back
    got_q.delete(); got_cyc.delete();
    rst_n = 1'b1;
    wait_words(5, 50);
    tick(3);
    check_init_words("init");
    for (int i = 1; i < 5 && i < got_cyc.size(); i++)
      check("init_b2b", got_cyc[i] - got_cyc[i-1], 1);
    check("init_count", got_q.size(), 5);
    check("init_done", init_done, 1'b1);
    check("init_busy", busy, 1'b0);
    check("init_valid", valid, 1'b0);

    // Table of digit refreshes
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      pulse(vecs[v].digits);
      wait_words(6, 100);
      tick(4);
      check("vec_count", got_q.size(), 6);
      for (int j = 0; j < 6 && j < got_q.size(); j++)
        check($sformatf("vec%0d_w%0d", v, j), got_q[j], vecs[v].exp[j]);
      check("vec_idle", busy, 1'b0);
    end

    // Ready stall mid-refresh
    got_q.delete();
    pulse(32'h00123456);
    wait_words(2, 50);
    ready = 1'b0;
    held = word;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_valid", valid, 1'b1);
      check("stall_word", word, held);
    end
    ready = 1'b1;
    wait_words(6, 50);
    tick(4);
    check("stall_count", got_q.size(), 6);
    for (int j = 0; j < 6 && j < got_q.size(); j++)
      check("stall_seq", got_q[j], vecs[0].exp[j]);

    // Two updates during one refresh collapse into one follow-up refresh
    got_q.delete();
    pulse(32'h00654321);
    wait_words(1, 50);
    pulse(32'h00000001);
    tick(1);
    pulse(32'h00000002);
    wait_words(12, 100);
    tick(6);
    check("dbl_count", got_q.size(), 12);
    for (int j = 0; j < 6 && j < got_q.size(); j++)
      check("dbl_first", got_q[j], make_exp(j + 1, j + 1));
    for (int j = 6; j < 12 && j < got_q.size(); j++)
      check("dbl_second", got_q[j], make_exp(j - 5, (j == 6) ? 2 : 0));

    // Intensity change wins over a pending refresh
    got_q.delete();
    intensity = 4'hC;
    pulse(32'h00000042);
    wait_words(7, 100);
    tick(10);
    check("int_count", got_q.size(), 7);
    if (got_q.size() > 0) check("int_first", got_q[0], 16'h0A0C);
    for (int j = 1; j < 7 && j < got_q.size(); j++)
      check("int_digits", got_q[j], make_exp(j, (j == 1) ? 2 : (j == 2) ? 4 : 0));

    // Reset during a refresh
    got_q.delete();
    pulse(32'h00123456);
    wait_words(2, 50);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    got_q.delete();
    rst_n = 1'b1;
    wait_words(6, 60);
    tick(4);
    check_init_words("reinit");
    check("reinit_count", got_q.size(), 6);
    if (got_q.size() > 5) check("reinit_intens", got_q[5], 16'h0A0C);

    // Enable dropped mid-refresh: in-flight word completes, then resume at same index
    got_q.delete();
    pulse(32'h00000777);
    wait_words(2, 50);
    en = 1'b0;
    tick(6);
    check("en_hold_valid", valid, 1'b0);
    check("en_hold_count", got_q.size(), 3);
    en = 1'b1;
    wait_words(6, 50);
    tick(4);
    check("en_count", got_q.size(), 6);
    for (int j = 0; j < 6 && j < got_q.size(); j++)
      check("en_seq", got_q[j], make_exp(j + 1, (j < 3) ? 7 : 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [15:0] make_exp(input int addr, input int val);
    return {4'h0, 4'(addr), 8'(val)};
  endfunction

endmodule
